// File: rtl/load_reader.sv
// rtl/load_reader.sv - load unit: word-aligned memory read, lane extraction and sign/zero extension
module load_reader #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic        misaligned;
    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] extracted;

    assign misaligned = (size == 2'b11) ||
                        (size == 2'b01 && addr[0]) ||
                        (size == 2'b00 && addr[1:0] != 2'b00);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = misaligned ? ERR : REQ;
            REQ:     state_nxt = (MEM_LAT > 1) ? WAIT : CAPTURE;
            // cnt==1 here means it reaches 0 on this edge
            WAIT:    if (cnt == 3'd1) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shifted   = mem_data >> {off_q, 3'b000};
        lane_b    = shifted[7:0];
        lane_h    = off_q[1] ? mem_data[31:16] : mem_data[15:0];
        extracted = mem_data;
        case (size_q)
            2'b01:   extracted = {{16{sign_q & lane_h[15]}}, lane_h};
            2'b10:   extracted = {{24{sign_q & lane_b[7]}}, lane_b};
            default: extracted = mem_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            sign_q    <= 1'b0;
            mem_addr  <= 32'd0;
            load_data <= 32'd0;
            done      <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            state    <= state_nxt;
            done     <= (state == CAPTURE) || (state == ERR);
            misalign <= (state == ERR);
            if (state == IDLE && start) begin
                mem_addr <= {addr[31:2], 2'b00};
                off_q    <= addr[1:0];
                size_q   <= size;
                sign_q   <= sign;
            end
            if (state == REQ)
                cnt <= LAT_M1;
            else if (state == WAIT)
                cnt <= cnt - 3'd1;
            if (state == CAPTURE)
                load_data <= extracted;
        end
    end

    assign mem_rd = (state == REQ);
    assign busy   = (state != IDLE);

endmodule
